demo_cmd_responder: RTL and testbench

DEMO_CMD_RESPONDER -- requirements
Module: demo_cmd_responder

---
 rtl/demo_pkg.sv | 35 +++
 rtl/demo_lfsr.sv | 25 ++
 rtl/demo_cmd_responder.sv | 180 ++++++++++++++++++
 tb/tb_demo_cmd_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demo_pkg.sv
// Shared constants for the command responder: opcodes, FSM states, LFSR seed/taps and step.
// No logic of its own; imported by demo_lfsr and demo_cmd_responder.
package demo_pkg;

    localparam logic [7:0] OP_LFSR_WRITE = 8'h01;
    localparam logic [7:0] OP_ROM_READ   = 8'h02;
    localparam logic [7:0] OP_RAM_READ   = 8'h03;
    localparam logic [7:0] OP_IN         = 8'h04;
    localparam logic [7:0] OP_OUT        = 8'h05;

    localparam int          LFSR_W      = 24;
    localparam logic [23:0] LFSR_SEED   = 24'hFFFF_FF;
    localparam logic [23:0] LFSR_ZERO   = 24'h00_0001;
    // Bits 23,22,21,16 feed the XOR (polynomial taps 24,23,22,17).
    localparam logic [23:0] LFSR_TAPS   = 24'hE1_0000;

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_ARG0   = 3'd1,
        ST_ARG1   = 3'd2,
        ST_ARG2   = 3'd3,
        ST_MEM_RD = 3'd4,
        ST_TX     = 3'd5,
        ST_SINK   = 3'd6
    } state_t;

    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return {s[22:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        return (op >= OP_LFSR_WRITE) && (op <= OP_OUT);
    endfunction

endpackage

// File: rtl/demo_lfsr.sv
// 24-bit Fibonacci LFSR with synchronous load (zero maps to 1) and single-step advance.
// Latency: load/advance visible on state the cycle after the request.
// Backpressure: none; the caller gates advance with its own handshake.
module demo_lfsr
    import demo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (load) begin
            state <= (load_val == '0) ? LFSR_ZERO : load_val;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/demo_cmd_responder.sv
// Byte-stream command responder: LFSR load, ROM/RAM streaming, LFSR IN source, OUT sink.
// Latency: memory streams start 2 cycles after the last arg byte, then 1 byte/cycle.
// Backpressure: tx stalls hold data stable; a 2-entry output/skid pair absorbs the 1-cycle read pipe.
// Optional DEMO_CMD_RESPONDER_OUT_CHECK_EN: compare OUT bytes with the LFSR into sticky error_o.
module demo_cmd_responder
    import demo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  mem_sel_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [7:0]            mem_data_i,
    output logic [23:0]           lfsr_o,
    output logic                  error_o
);

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, arg0_q, arg1_q;
    logic [24:0] len_w, cnt_q, rd_left_q;
    logic        rx_rdy, rx_acc, tx_acc, mem_pop, rd_issue, is_mem_op, last;
    logic        pend_q, skid_vld_q, tx_vld_q;
    logic [7:0]  skid_dat_q, tx_dat_q;
    logic [1:0]  occ;
    logic        lfsr_load, lfsr_adv;

    assign len_w      = {1'b0, rx_data_i, arg1_q, arg0_q} + 25'd1;
    assign is_mem_op  = (opcode_q == OP_ROM_READ) || (opcode_q == OP_RAM_READ);
    assign rx_ready_o = rx_rdy & ~rst_i;
    assign tx_valid_o = (tx_vld_q | (state_q == ST_TX)) & ~rst_i;
    assign tx_data_o  = (state_q == ST_TX) ? lfsr_o[7:0] : tx_dat_q;
    assign rx_acc     = rx_valid_i & rx_ready_o;
    assign tx_acc     = tx_valid_o & tx_ready_i;
    assign mem_pop    = tx_vld_q & tx_ready_i;
    assign last       = (cnt_q == 25'd1);

    // A read may issue only if its data will find a free slot next cycle.
    assign occ      = {1'b0, tx_vld_q} + {1'b0, skid_vld_q} + {1'b0, pend_q};
    assign rd_issue = (state_q == ST_MEM_RD) && (rd_left_q != '0) && ((occ < 2'd2) || mem_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_CMD;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rx_rdy    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state_q)
            ST_CMD: begin
                rx_rdy = 1'b1;
                if (rx_acc && op_known(rx_data_i)) state_d = ST_ARG0;
            end
            ST_ARG0: begin
                rx_rdy = 1'b1;
                if (rx_acc) state_d = ST_ARG1;
            end
            ST_ARG1: begin
                rx_rdy = 1'b1;
                if (rx_acc) state_d = ST_ARG2;
            end
            ST_ARG2: begin
                rx_rdy = 1'b1;
                if (rx_acc) begin
                    case (opcode_q)
                        OP_LFSR_WRITE: begin
                            lfsr_load = 1'b1;
                            state_d   = ST_CMD;
                        end
                        OP_ROM_READ, OP_RAM_READ: state_d = ST_MEM_RD;
                        OP_IN:                    state_d = ST_TX;
                        OP_OUT:                   state_d = ST_SINK;
                        default:                  state_d = ST_CMD;
                    endcase
                end
            end
            ST_MEM_RD: begin
                if (tx_acc && last) state_d = ST_CMD;
            end
            ST_TX: begin
                lfsr_adv = tx_acc;
                if (tx_acc && last) state_d = ST_CMD;
            end
            ST_SINK: begin
                rx_rdy   = 1'b1;
                lfsr_adv = rx_acc;
                if (rx_acc && last) state_d = ST_CMD;
            end
            default: state_d = ST_CMD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            opcode_q   <= '0;
            arg0_q     <= '0;
            arg1_q     <= '0;
            cnt_q      <= '0;
            rd_left_q  <= '0;
            pend_q     <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            tx_vld_q   <= 1'b0;
            tx_dat_q   <= '0;
            mem_sel_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            if (state_q == ST_CMD  && rx_acc) opcode_q <= rx_data_i;
            if (state_q == ST_ARG0 && rx_acc) arg0_q   <= rx_data_i;
            if (state_q == ST_ARG1 && rx_acc) arg1_q   <= rx_data_i;

            if (state_q == ST_ARG2 && rx_acc) begin
                cnt_q     <= len_w;
                rd_left_q <= is_mem_op ? len_w : '0;
                if (is_mem_op) begin
                    mem_sel_o  <= (opcode_q == OP_RAM_READ);
                    mem_addr_o <= '0;
                end
            end else begin
                if (tx_acc || (state_q == ST_SINK && rx_acc)) cnt_q <= cnt_q - 25'd1;
                if (rd_issue) begin
                    rd_left_q  <= rd_left_q - 25'd1;
                    mem_addr_o <= mem_addr_o + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            pend_q <= rd_issue;

            // Output register refills from the skid first, then from the arriving read.
            if (!tx_vld_q || mem_pop) begin
                if (skid_vld_q) begin
                    tx_dat_q   <= skid_dat_q;
                    tx_vld_q   <= 1'b1;
                    skid_vld_q <= pend_q;
                    skid_dat_q <= mem_data_i;
                end else if (pend_q) begin
                    tx_dat_q <= mem_data_i;
                    tx_vld_q <= 1'b1;
                end else begin
                    tx_vld_q <= 1'b0;
                end
            end else if (pend_q) begin
                skid_vld_q <= 1'b1;
                skid_dat_q <= mem_data_i;
            end
        end
    end

    demo_lfsr u_lfsr (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (lfsr_load),
        .load_val ({rx_data_i, arg1_q, arg0_q}),
        .advance  (lfsr_adv),
        .state    (lfsr_o)
    );

`ifdef DEMO_CMD_RESPONDER_OUT_CHECK_EN
    logic error_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || lfsr_load) begin
            error_q <= 1'b0;
        end else if (state_q == ST_SINK && rx_acc && rx_data_i != lfsr_o[7:0]) begin
            error_q <= 1'b1;
        end
    end
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_demo_cmd_responder.sv
// Directed bench for demo_cmd_responder: expected tx bytes come from a queue filled by a
// software LFSR / memory-image model; one negedge process checks every tx transfer.
module tb_demo_cmd_responder;

    localparam int AW = 10;
`ifdef DEMO_CMD_RESPONDER_OUT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [7:0]    rx_data_i = '0;
    logic          rx_valid_i = 1'b0;
    logic          rx_ready_o;
    logic [7:0]    tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready_i = 1'b1;
    logic          mem_sel_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_data_i = '0;
    logic [23:0]   lfsr_o;
    logic          error_o;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rom[1024];
    logic [7:0]  ram[1024];
    bit          stall_en = 1'b0;
    logic [23:0] mlfsr;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_dat = '0;
    logic [AW-1:0] m_a;
    logic        m_s;

    demo_cmd_responder #(.ADDR_WIDTH(AW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .mem_sel_o  (mem_sel_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .lfsr_o     (lfsr_o),
        .error_o    (error_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        bad++;
        $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Software LFSR straight from the polynomial description.
    function automatic logic [23:0] model_next(input logic [23:0] s);
        return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
    endfunction

    // Synchronous-read memory: data for the address seen in a cycle appears the next cycle.
    initial forever begin
        @(negedge clk);
        m_a = mem_addr_o;
        m_s = mem_sel_o;
        @(posedge clk);
        #1 mem_data_i = m_s ? ram[m_a] : rom[m_a];
    end

    initial forever begin
        @(posedge clk);
        #1 tx_ready_i = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Transfer checker: in-order data, stability under stall, no extra bytes.
    initial forever begin
        @(negedge clk);
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("tx_hold_valid", tx_valid_o, 1);
                if (tx_valid_o) chk("tx_hold_data", tx_data_o, prev_dat);
            end
            if (tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0) fail("tx_unexpected", tx_data_o, 0);
                else chk("tx_data", tx_data_o, exp_q.pop_front());
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_dat   = tx_data_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        waited = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk);
        while (!rx_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready_o) fail("rx_timeout", rx_ready_o, 1);
        @(posedge clk);
        #1 rx_valid_i = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [23:0] arg);
        int w;
        send_byte(op, w);
        send_byte(arg[7:0], w);
        send_byte(arg[15:8], w);
        send_byte(arg[23:16], w);
    endtask

    task automatic push_in(input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(mlfsr[7:0]);
            mlfsr = model_next(mlfsr);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            realign();
            n++;
        end
        if (exp_q.size() != 0) begin
            fail("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) realign();
    endtask

    task automatic run_out(input logic [23:0] seed, input int bad_idx);
        int w;
        send_cmd(8'h01, seed);
        mlfsr = seed;
        send_cmd(8'h05, 24'd9);
        for (int i = 0; i < 10; i++) begin
            send_byte(mlfsr[7:0] ^ ((i == bad_idx) ? 8'h10 : 8'h00), w);
            chk("sink_wait", w, 0);
            mlfsr = model_next(mlfsr);
        end
    endtask

    initial begin
        int n, t0;
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 8'(i * 13 + 5);
            ram[i] = 8'(i ^ (i >> 2)) ^ 8'hA5;
        end

        // Reset values
        @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready_low", rx_ready_o, 0);
        chk("rst_tx_valid", tx_valid_o, 0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready_high", rx_ready_o, 1);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_mem_sel", mem_sel_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_lfsr", lfsr_o, 24'hFFFFFF);
        chk("rst_error", error_o, 0);
        realign();

        // Unknown opcode discarded, then LFSR_WRITE 01 81 38 33
        send_byte(8'h7E, n);
        send_cmd(8'h01, 24'h333881);
        @(negedge clk);
        chk("lfsr_write", lfsr_o, 24'h333881);
        realign();

        // ARG 0 loads 1; IN of 10 bytes
        send_cmd(8'h01, 24'h000000);
        @(negedge clk);
        chk("lfsr_zero_load", lfsr_o, 24'h000001);
        realign();
        mlfsr = 24'h000001;
        push_in(10);
        send_cmd(8'h04, 24'd9);
        drain(200);
        @(negedge clk);
        chk("in_lfsr_literal", lfsr_o, 24'h000400);
        chk("in_lfsr_model", lfsr_o, mlfsr);
        realign();

        // ROM stream with tx_ready held high: one byte per cycle
        for (int i = 0; i < 1024; i++) exp_q.push_back(rom[i]);
        send_cmd(8'h02, 24'd1023);
        n = 0;
        while (exp_q.size() == 1024 && n < 100) begin realign(); n++; end
        t0 = n;
        while (exp_q.size() != 0 && n < 3000) begin realign(); n++; end
        chk("rom_rate", n - t0, 1023);
        drain(10);
        @(negedge clk);
        chk("rom_sel", mem_sel_o, 0);
        realign();

        // Same ROM stream under random stalls
        stall_en = 1'b1;
        for (int i = 0; i < 1024; i++) exp_q.push_back(rom[i]);
        send_cmd(8'h02, 24'd1023);
        drain(8000);
        stall_en = 1'b0;

        // RAM stream wrapping past the end: last byte is RAM[0]
        for (int i = 0; i <= 1024; i++) exp_q.push_back(ram[i % 1024]);
        send_cmd(8'h03, 24'd1024);
        drain(3000);
        @(negedge clk);
        chk("ram_sel", mem_sel_o, 1);
        realign();

        // OUT with correct bytes, then with byte 5 corrupted
        run_out(24'h5A5A5A, -1);
        @(negedge clk);
        chk("out_ok_error", error_o, 0);
        chk("out_ok_lfsr", lfsr_o, mlfsr);
        chk("out_back_to_cmd", rx_ready_o, 1);
        realign();
        run_out(24'h5A5A5A, 5);
        @(negedge clk);
        chk("out_bad_error", error_o, ERR_EXP);
        chk("out_bad_lfsr", lfsr_o, mlfsr);
        realign();
        send_cmd(8'h01, 24'h000001);
        @(negedge clk);
        chk("error_cleared", error_o, 0);
        realign();

        // Reset after 3 of 10 IN bytes
        mlfsr = 24'h000001;
        push_in(10);
        send_cmd(8'h04, 24'd9);
        n = 0;
        while (exp_q.size() > 7 && n < 100) begin realign(); n++; end
        chk("mid_rst_progress", exp_q.size(), 7);
        rst_i = 1'b1;
        exp_q.delete();
        realign();
        rst_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx_valid", tx_valid_o, 0);
        chk("mid_rst_lfsr", lfsr_o, 24'hFFFFFF);
        realign();
        mlfsr = 24'hFFFFFF;
        push_in(2);
        send_cmd(8'h04, 24'd1);
        drain(100);
        @(negedge clk);
        chk("post_rst_lfsr", lfsr_o, 24'hFFFFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
